// File: rtl/shift_feeder.sv
// shift_feeder: accepts a parallel word and replays it MSB-first as strobed serial bits
module shift_feeder #(
  parameter int WIDTH = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             shift_enable,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, STROBE, GAP, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t state;
  logic [WIDTH-1:0] word;
  logic [CW-1:0] cnt;
  logic [7:0] gcnt;
  logic bit_q;
  logic open;
  logic last;
  assign open = state == IDLE || state == DONE;
  assign last = cnt == LAST;
  // A gap also follows the final strobe, so done lands WIDTH*(GAP_CYCLES+1) cycles after accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      word <= '0;
      cnt <= '0;
      gcnt <= '0;
      bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= in_valid ? STROBE : IDLE;
          if (in_valid) begin
            bit_q <= in_data[WIDTH-1];
            word <= in_data << 1;
            cnt <= '0;
          end
        end
        STROBE: begin
          if (GAP_CYCLES > 0) begin
            state <= GAP;
            gcnt <= GAP_LOAD;
          end else if (last) begin
            state <= DONE;
          end else begin
            bit_q <= word[WIDTH-1];
            word <= word << 1;
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (gcnt != 8'd0) begin
            gcnt <= gcnt - 8'd1;
          end else if (last) begin
            state <= DONE;
          end else begin
            state <= STROBE;
            bit_q <= word[WIDTH-1];
            word <= word << 1;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready = !reset && open;
  assign data = bit_q;
  assign shift_enable = state == STROBE;
  assign busy = state == STROBE || state == GAP;
  assign done = state == DONE;
endmodule

// File: tb/tb_shift_feeder.sv
// tb_shift_feeder: directed checks of serialization, gaps, back-to-back words and reset abort
module tb_shift_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] d0_din = '0, d1_din = '0;
  logic [3:0] d2_din = '0;
  logic d0_valid = 1'b0, d1_valid = 1'b0, d2_valid = 1'b0;
  logic d0_ready, d0_bit, d0_se, d0_busy, d0_done;
  logic d1_ready, d1_bit, d1_se, d1_busy, d1_done;
  logic d2_ready, d2_bit, d2_se, d2_busy, d2_done;
  logic [7:0] sr0, sr1;
  logic [3:0] sr2;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  shift_feeder u0 (.clk(clk), .reset(reset), .in_data(d0_din), .in_valid(d0_valid),
    .in_ready(d0_ready), .data(d0_bit), .shift_enable(d0_se), .busy(d0_busy), .done(d0_done));
  shift_feeder #(.WIDTH(8), .GAP_CYCLES(2)) u1 (.clk(clk), .reset(reset), .in_data(d1_din),
    .in_valid(d1_valid), .in_ready(d1_ready), .data(d1_bit), .shift_enable(d1_se),
    .busy(d1_busy), .done(d1_done));
  shift_feeder #(.WIDTH(4), .GAP_CYCLES(1)) u2 (.clk(clk), .reset(reset), .in_data(d2_din),
    .in_valid(d2_valid), .in_ready(d2_ready), .data(d2_bit), .shift_enable(d2_se),
    .busy(d2_busy), .done(d2_done));

  // Downstream SIPO stages: shift left, insert at LSB on each strobe
  always @(posedge clk) begin
    sr0 <= reset ? 8'h00 : d0_se ? {sr0[6:0], d0_bit} : sr0;
    sr1 <= reset ? 8'h00 : d1_se ? {sr1[6:0], d1_bit} : sr1;
    sr2 <= reset ? 4'h0 : d2_se ? {sr2[2:0], d2_bit} : sr2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word on the GAP_CYCLES=0 instance; optionally pulse in_valid with 8'h0F at offset pulse_at
  task automatic run0(input logic [7:0] w, input int pulse_at);
    chk("d0_ready_before", 32'(d0_ready), 32'd1);
    d0_din = w;
    d0_valid = 1'b1;
    @(negedge clk);
    d0_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) begin
        chk("d0_se", 32'(d0_se), 32'd1);
        chk("d0_bit", 32'(d0_bit), 32'(w[8-k]));
        chk("d0_busy", 32'(d0_busy), 32'd1);
        chk("d0_ready_busy", 32'(d0_ready), 32'd0);
        chk("d0_done_early", 32'(d0_done), 32'd0);
      end else begin
        chk("d0_done", 32'(d0_done), 32'd1);
        chk("d0_se_done", 32'(d0_se), 32'd0);
        chk("d0_busy_done", 32'(d0_busy), 32'd0);
        chk("d0_ready_done", 32'(d0_ready), 32'd1);
        chk("d0_sipo", 32'(sr0), 32'(w));
      end
      if (k == pulse_at) begin
        d0_din = 8'h0F;
        d0_valid = 1'b1;
      end else if (k == pulse_at + 1) begin
        d0_valid = 1'b0;
      end
      if (k < 9) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [3:0] w4;
    logic prev_se;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(d0_ready), 32'd0);
    chk("rst_se", 32'(d0_se), 32'd0);
    chk("rst_busy", 32'(d0_busy), 32'd0);
    chk("rst_done", 32'(d0_done), 32'd0);
    chk("rst_data", 32'(d0_bit), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(d0_ready), 32'd1);
    // 1: A5 with no gap
    run0(8'hA5, 0);
    @(negedge clk);
    chk("t1_idle_done", 32'(d0_done), 32'd0);
    chk("t1_idle_busy", 32'(d0_busy), 32'd0);
    // 3: back-to-back, second word accepted in DONE
    d0_din = 8'h01;
    d0_valid = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      w = k <= 9 ? 8'h01 : 8'h80;
      if (k == 9 || k == 18) begin
        chk("t3_done", 32'(d0_done), 32'd1);
        chk("t3_ready", 32'(d0_ready), 32'd1);
        chk("t3_sipo", 32'(sr0), 32'(w));
      end else begin
        chk("t3_se", 32'(d0_se), 32'd1);
        chk("t3_bit", 32'(d0_bit), 32'(w[(k <= 9) ? 8 - k : 17 - k]));
        chk("t3_done_low", 32'(d0_done), 32'd0);
      end
      if (k == 9) d0_din = 8'h80;
      if (k == 10) d0_valid = 1'b0;
    end
    @(negedge clk);
    chk("t3_idle", 32'(d0_done), 32'd0);
    // 4: ignored in_valid pulse mid-word
    run0(8'hF0, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_no_extra_se", 32'(d0_se), 32'd0);
      chk("t4_no_extra_done", 32'(d0_done), 32'd0);
    end
    // 5: reset after third strobe of FF
    d0_din = 8'hFF;
    d0_valid = 1'b1;
    @(negedge clk);
    d0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("t5_se", 32'(d0_se), 32'd1);
      chk("t5_bit", 32'(d0_bit), 32'd1);
      if (k < 3) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t5_abort_se", 32'(d0_se), 32'd0);
    chk("t5_abort_data", 32'(d0_bit), 32'd0);
    chk("t5_abort_busy", 32'(d0_busy), 32'd0);
    chk("t5_abort_done", 32'(d0_done), 32'd0);
    chk("t5_abort_ready", 32'(d0_ready), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_no_done", 32'(d0_done), 32'd0);
      chk("t5_no_se", 32'(d0_se), 32'd0);
    end
    run0(8'h81, 0);
    @(negedge clk);
    // 2: GAP_CYCLES=2, 3C
    w = 8'h3C;
    d1_din = w;
    d1_valid = 1'b1;
    prev_se = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      d1_valid = 1'b0;
      if (k <= 22 && (k - 1) % 3 == 0) begin
        chk("t2_se", 32'(d1_se), 32'd1);
        chk("t2_bit", 32'(d1_bit), 32'(w[7 - (k - 1) / 3]));
      end else begin
        chk("t2_se_gap", 32'(d1_se), 32'd0);
      end
      chk("t2_busy", 32'(d1_busy), 32'(k <= 24));
      chk("t2_done", 32'(d1_done), 32'(k == 25));
      chk("t2_no_back2back", 32'(prev_se && d1_se), 32'd0);
      prev_se = d1_se;
    end
    chk("t2_sipo", 32'(sr1), 32'h3C);
    // 6: WIDTH=4, GAP_CYCLES=1, C
    w4 = 4'hC;
    d2_din = w4;
    d2_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      d2_valid = 1'b0;
      chk("t6_se", 32'(d2_se), 32'(k <= 7 && k % 2 == 1));
      if (k <= 7 && k % 2 == 1) chk("t6_bit", 32'(d2_bit), 32'(w4[3 - (k - 1) / 2]));
      chk("t6_done", 32'(d2_done), 32'(k == 9));
    end
    chk("t6_sipo", 32'(sr2), 32'hC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
